// File: rtl/hs_upload_responder_if.sv
// rtl/hs_upload_responder_if.sv - ioctl upload, RAM window and CPU pause signal bundle
interface hs_upload_responder_if #(
    parameter int AW = 12
);
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_upload_req;
    logic          save_trigger;
    logic          ram_wr_mon;
    logic [AW-1:0] ram_addr_mon;
    logic [AW-1:0] ram_address;
    logic          ram_access;
    logic [7:0]    ram_data;
    logic          pause_req;
    logic          paused;
    logic          busy;

    // The responder is the slave; hps_io, the core RAM and the CPU form the master side.
    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_index, ioctl_addr, save_trigger,
        input  ram_wr_mon, ram_addr_mon, ram_data, paused,
        output ioctl_din, ioctl_upload_req, ram_address, ram_access, pause_req, busy
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_index, ioctl_addr, save_trigger,
        output ram_wr_mon, ram_addr_mon, ram_data, paused,
        input  ioctl_din, ioctl_upload_req, ram_address, ram_access, pause_req, busy
    );
endinterface

// File: rtl/hs_upload_responder.sv
// rtl/hs_upload_responder.sv - serves hiscore/NVRAM window uploads to HPS and requests saves when dirty
module hs_upload_responder #(
    parameter int            AW           = 12,
    parameter logic [AW-1:0] BASE_ADDR    = '0,
    parameter int            LENGTH       = 256,
    parameter logic [7:0]    UPLOAD_INDEX = 8'd4,
    parameter int            PAUSE_PAD    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    hs_upload_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE_WAIT,
        S_PAD,
        S_READY,
        S_FETCH,
        S_LATCH
    } state_t;

    localparam logic [24:0] LEN_OFF  = 25'(LENGTH);
    localparam logic [AW:0] LEN_WIN  = (AW+1)'(LENGTH);
    localparam logic [AW:0] BASE_WIN = {1'b0, BASE_ADDR};
    localparam logic [3:0]  PAD_INIT = 4'(PAUSE_PAD - 1);

    state_t      state;
    logic [3:0]  pad_cnt;
    logic        pending;
    logic [24:0] pend_off;
    logic        in_range;
    logic        dirty;
    logic        trig_prev;

    logic        active;
    logic        trig_edge;
    logic        wr_in_win;
    logic [AW:0] wr_rel;
    logic [24:0] fetch_off;
    logic        fetch_in_range;

    assign active    = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
    assign trig_edge = bus.save_trigger && !trig_prev;

    // Offset from the window base in AW+1 bits: addresses below the base borrow
    // into the top bit and so can never compare below LENGTH.
    assign wr_rel    = {1'b0, bus.ram_addr_mon} - BASE_WIN;
    assign wr_in_win = bus.ram_wr_mon && (wr_rel < LEN_WIN);

    // A strobe arriving in READY is newer than anything parked in pend_off.
    assign fetch_off      = bus.ioctl_rd ? bus.ioctl_addr : pend_off;
    assign fetch_in_range = fetch_off < LEN_OFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= S_IDLE;
            pad_cnt              <= '0;
            pending              <= 1'b0;
            pend_off             <= '0;
            in_range             <= 1'b0;
            dirty                <= 1'b0;
            trig_prev            <= 1'b0;
            bus.ioctl_din        <= 8'h00;
            bus.ioctl_upload_req <= 1'b0;
            bus.ram_address      <= '0;
            bus.ram_access       <= 1'b0;
            bus.pause_req        <= 1'b0;
            bus.busy             <= 1'b0;
        end else begin
            trig_prev            <= bus.save_trigger;
            bus.ioctl_upload_req <= trig_edge && dirty && (state == S_IDLE) && !bus.ioctl_upload;

            if (state != S_IDLE && !active) begin
                // Upload ended or retargeted: drop everything, release the CPU.
                state          <= S_IDLE;
                bus.ram_access <= 1'b0;
                bus.pause_req  <= 1'b0;
                bus.busy       <= 1'b0;
                pending        <= 1'b0;
                dirty          <= wr_in_win;
            end else begin
                if (wr_in_win) begin
                    dirty <= 1'b1;
                end

                if (bus.ioctl_rd && active && state != S_READY) begin
                    pending  <= 1'b1;
                    pend_off <= bus.ioctl_addr;
                end

                case (state)
                    S_IDLE: begin
                        if (active) begin
                            state         <= S_PAUSE_WAIT;
                            bus.pause_req <= 1'b1;
                            bus.busy      <= 1'b1;
                        end
                    end
                    S_PAUSE_WAIT: begin
                        if (bus.paused) begin
                            state   <= S_PAD;
                            pad_cnt <= PAD_INIT;
                        end
                    end
                    S_PAD: begin
                        if (pad_cnt == 4'd0) begin
                            state <= S_READY;
                        end else begin
                            pad_cnt <= pad_cnt - 4'd1;
                        end
                    end
                    S_READY: begin
                        if (bus.ioctl_rd || pending) begin
                            state    <= S_FETCH;
                            pending  <= 1'b0;
                            in_range <= fetch_in_range;
                            if (fetch_in_range) begin
                                bus.ram_access  <= 1'b1;
                                bus.ram_address <= BASE_ADDR + fetch_off[AW-1:0];
                            end
                        end
                    end
                    S_FETCH: begin
                        bus.ram_access <= 1'b0;
                        state          <= S_LATCH;
                    end
                    S_LATCH: begin
                        bus.ioctl_din <= in_range ? bus.ram_data : 8'hFF;
                        state         <= S_READY;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hs_upload_responder.sv
// tb/tb_hs_upload_responder.sv - directed self-checking bench for hs_upload_responder
module tb_hs_upload_responder;

    localparam int AW = 12;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   acc_base;
    logic [7:0] mem [0:4095];
    logic [7:0] exp_q [$];
    logic [7:0] last_din;

    hs_upload_responder_if #(.AW(AW)) bus ();

    hs_upload_responder #(
        .AW(AW), .BASE_ADDR(12'h000), .LENGTH(256), .UPLOAD_INDEX(8'd4), .PAUSE_PAD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_access) begin
            bus.ram_data <= mem[bus.ram_address];
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [24:0] off);
        exp_q.push_back((off < 25'd256) ? mem[off[11:0]] : 8'hFF);
    endtask

    task automatic pop_din(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            last_din = e;
            chk(tag, 32'(bus.ioctl_din), 32'(e));
        end
    endtask

    task automatic ram_write(input logic [11:0] a);
        bus.ram_wr_mon   = 1'b1;
        bus.ram_addr_mon = a;
        step(1);
        bus.ram_wr_mon   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[16] = 8'hA5;
        reset            = 1'b1;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_index  = 8'd0;
        bus.ioctl_addr   = '0;
        bus.save_trigger = 1'b0;
        bus.ram_wr_mon   = 1'b0;
        bus.ram_addr_mon = '0;
        bus.paused       = 1'b0;
        step(2);
        chk("rst_din", 32'(bus.ioctl_din), 32'h0);
        chk("rst_req", 32'(bus.ioctl_upload_req), 32'h0);
        chk("rst_access", 32'(bus.ram_access), 32'h0);
        chk("rst_address", 32'(bus.ram_address), 32'h0);
        chk("rst_pause", 32'(bus.pause_req), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        step(1);

        // 1: basic served read
        bus.ioctl_index  = 8'd4;
        bus.ioctl_upload = 1'b1;
        step(1);
        chk("t1_pause_req", 32'(bus.pause_req), 32'h1);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        step(2);
        bus.paused = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t1_no_access_pad", 32'(bus.ram_access), 32'h0);
        end
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'h10;
        push_exp(25'h10);
        step(1);
        bus.ioctl_rd = 1'b0;
        chk("t1_access", 32'(bus.ram_access), 32'h1);
        chk("t1_address", 32'(bus.ram_address), 32'h10);
        chk("t1_din_early", 32'(bus.ioctl_din), 32'h0);
        step(1);
        chk("t1_access_off", 32'(bus.ram_access), 32'h0);
        step(1);
        pop_din("t1_din");

        // 2: out-of-window offset returns 0xFF without touching RAM
        acc_base = acc_cnt;
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'd300;
        push_exp(25'd300);
        step(1);
        bus.ioctl_rd = 1'b0;
        chk("t2_no_access", 32'(bus.ram_access), 32'h0);
        step(2);
        pop_din("t2_din_ff");
        chk("t2_access_count", 32'(acc_cnt - acc_base), 32'd0);

        // 3: early strobes collapse to the last one; upload end releases pause
        bus.ioctl_upload = 1'b0;
        step(1);
        chk("t3_idle_busy", 32'(bus.busy), 32'h0);
        bus.paused       = 1'b0;
        bus.ioctl_upload = 1'b1;
        step(1);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'd0;
        step(1);
        bus.ioctl_addr = 25'd1;
        push_exp(25'd1);
        step(1);
        bus.ioctl_rd = 1'b0;
        acc_base     = acc_cnt;
        bus.paused   = 1'b1;
        step(8);
        pop_din("t3_din_last_rd");
        chk("t3_address", 32'(bus.ram_address), 32'h1);
        chk("t3_single_fetch", 32'(acc_cnt - acc_base), 32'd1);
        chk("t3_pause_held", 32'(bus.pause_req), 32'h1);
        bus.ioctl_upload = 1'b0;
        step(1);
        chk("t3_pause_drop", 32'(bus.pause_req), 32'h0);
        chk("t3_busy_drop", 32'(bus.busy), 32'h0);

        // 4: save request generation
        ram_write(12'h005);
        bus.save_trigger = 1'b1;
        step(1);
        chk("t4_req_pulse", 32'(bus.ioctl_upload_req), 32'h1);
        step(1);
        chk("t4_req_one_clk", 32'(bus.ioctl_upload_req), 32'h0);
        bus.save_trigger = 1'b0;
        bus.ioctl_upload = 1'b1;
        step(1);
        bus.ioctl_upload = 1'b0;
        step(2);
        ram_write(12'h100);
        bus.save_trigger = 1'b1;
        step(1);
        chk("t4_outside_no_req_a", 32'(bus.ioctl_upload_req), 32'h0);
        step(1);
        chk("t4_outside_no_req_b", 32'(bus.ioctl_upload_req), 32'h0);
        bus.save_trigger = 1'b0;
        ram_write(12'h005);
        bus.ioctl_upload = 1'b1;
        step(2);
        bus.save_trigger = 1'b1;
        step(1);
        chk("t4_busy_no_req_a", 32'(bus.ioctl_upload_req), 32'h0);
        step(1);
        chk("t4_busy_no_req_b", 32'(bus.ioctl_upload_req), 32'h0);
        bus.save_trigger = 1'b0;
        bus.ioctl_upload = 1'b0;
        step(2);

        // 5: foreign index is ignored
        bus.ioctl_index  = 8'd0;
        bus.ioctl_upload = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.ioctl_rd   = (i == 2);
            bus.ioctl_addr = 25'h10;
            step(1);
            chk("t5_no_pause", 32'(bus.pause_req), 32'h0);
        end
        bus.ioctl_rd = 1'b0;
        chk("t5_busy", 32'(bus.busy), 32'h0);
        chk("t5_din_unchanged", 32'(bus.ioctl_din), 32'(last_din));
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd4;
        step(1);

        // 6: asynchronous reset during FETCH
        ram_write(12'h005);
        bus.ioctl_upload = 1'b1;
        step(6);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'h20;
        step(1);
        bus.ioctl_rd = 1'b0;
        chk("t6_in_fetch", 32'(bus.ram_access), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_access_async", 32'(bus.ram_access), 32'h0);
        chk("t6_pause_async", 32'(bus.pause_req), 32'h0);
        chk("t6_busy_async", 32'(bus.busy), 32'h0);
        chk("t6_din_async", 32'(bus.ioctl_din), 32'h0);
        @(negedge clk);
        reset            = 1'b0;
        bus.ioctl_upload = 1'b0;
        step(1);
        bus.save_trigger = 1'b1;
        step(1);
        chk("t6_dirty_cleared_a", 32'(bus.ioctl_upload_req), 32'h0);
        step(1);
        chk("t6_dirty_cleared_b", 32'(bus.ioctl_upload_req), 32'h0);
        bus.save_trigger = 1'b0;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
